// File: rtl/lbp_scan_ctrl.sv
// Raster scan over interior pixels: gathers a 3x3 window (9 reads at row start, 3 after), issues it, writes back the result.
// Per pixel: fetch reads + issue + result wait + 1 write cycle; gray_ready, win_ready and res_valid stall in place.
module lbp_scan_ctrl #(
  parameter int IMG_W = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic [71:0]   win,
  output logic          win_valid,
  input  logic          win_ready,
  input  logic          res_valid,
  input  logic [7:0]    res_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);
  localparam int CW = AW / 2;
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 2);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RES, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   row, col;
  logic [1:0]      fi, fj;
  logic [8:0][7:0] win_q;
  logic [7:0]      res_q;
  logic            full_fetch, rd, rd_last, last_pix;
  logic [CW-1:0]   rd_row, rd_col;
  logic [3:0]      widx;

  // fi walks the window rows, fj the window columns (full fetch only)
  assign full_fetch = (col == CW'(1));
  assign rd_last    = (fi == 2'd2) && (!full_fetch || fj == 2'd2);
  assign last_pix   = (row == LAST) && (col == LAST);
  assign rd_row     = row + CW'(fi) - CW'(1);
  assign rd_col     = full_fetch ? CW'(fj) : col + CW'(1);
  assign widx       = 4'({fi, 1'b0}) + 4'(fi) + 4'(fj);

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    gray_req  = 1'b0;
    gray_addr = '0;
    win_valid = 1'b0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = 1'b0;
    win       = win_q;
    case (state)
      IDLE: begin
        if (gray_ready) state_nxt = FETCH;
      end
      FETCH: begin
        rd        = gray_ready;
        gray_req  = gray_ready;
        gray_addr = {rd_row, rd_col};
        if (gray_ready && rd_last) state_nxt = ISSUE;
      end
      ISSUE: begin
        win_valid = 1'b1;
        if (win_ready) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) state_nxt = WRITE;
      end
      WRITE: begin
        lbp_valid = 1'b1;
        lbp_addr  = {row, col};
        lbp_data  = res_q;
        state_nxt = last_pix ? DONE : FETCH;
      end
      DONE: begin
        finish = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= CW'(1);
      col   <= CW'(1);
      fi    <= 2'd0;
      fj    <= 2'd0;
      win_q <= '0;
      res_q <= 8'd0;
    end else begin
      state <= state_nxt;
      if (rd) begin
        if (rd_last) begin
          fi <= 2'd0;
          fj <= 2'd0;
        end else if (fi == 2'd2) begin
          fi <= 2'd0;
          fj <= fj + 2'd1;
        end else begin
          fi <= fi + 2'd1;
        end
        if (full_fetch) begin
          win_q[widx] <= gray_data;
        end else begin
          // first read of a column step slides the window left; new column lands in slot 2
          if (fi == 2'd0) begin
            for (int i = 0; i < 3; i++) begin
              win_q[3*i]   <= win_q[3*i+1];
              win_q[3*i+1] <= win_q[3*i+2];
            end
          end
          win_q[widx + 4'd2] <= gray_data;
        end
      end
      if (state == WAIT_RES && res_valid) res_q <= res_data;
      if (state == WRITE && !last_pix) begin
        if (col == LAST) begin
          col <= CW'(1);
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench: default-size instance for directed address/window checks, 16x16 instance for full-frame and restart checks.
module tb_lbp_scan_ctrl;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s, sel;
  logic        gray_ready, win_ready, res_valid;
  logic [7:0]  res_data;

  logic        d_req, d_wv, d_lv, d_fin;
  logic [13:0] d_addr, d_laddr;
  logic [71:0] d_win;
  logic [7:0]  d_ldata, d_gdata;
  logic        s_req, s_wv, s_lv, s_fin;
  logic [7:0]  s_addr, s_laddr;
  logic [71:0] s_win;
  logic [7:0]  s_ldata, s_gdata;
  logic [7:0]  mem_s [256];

  assign d_gdata = d_addr[7:0];
  assign s_gdata = mem_s[s_addr];

  lbp_scan_ctrl dut (
    .clk(clk), .reset(rst_d), .gray_ready(gray_ready), .gray_req(d_req), .gray_addr(d_addr),
    .gray_data(d_gdata), .win(d_win), .win_valid(d_wv), .win_ready(win_ready),
    .res_valid(res_valid), .res_data(res_data), .lbp_valid(d_lv), .lbp_addr(d_laddr),
    .lbp_data(d_ldata), .finish(d_fin)
  );

  lbp_scan_ctrl #(.IMG_W(16), .AW(8)) dut_s (
    .clk(clk), .reset(rst_s), .gray_ready(gray_ready), .gray_req(s_req), .gray_addr(s_addr),
    .gray_data(s_gdata), .win(s_win), .win_valid(s_wv), .win_ready(win_ready),
    .res_valid(res_valid), .res_data(res_data), .lbp_valid(s_lv), .lbp_addr(s_laddr),
    .lbp_data(s_ldata), .finish(s_fin)
  );

  logic        o_req, o_wv, o_lv, o_fin;
  logic [13:0] o_addr, o_laddr;
  logic [71:0] o_win;
  logic [7:0]  o_ldata;

  always_comb begin
    if (sel) begin
      o_req = s_req; o_addr = {6'd0, s_addr}; o_win = s_win; o_wv = s_wv;
      o_lv = s_lv; o_laddr = {6'd0, s_laddr}; o_ldata = s_ldata; o_fin = s_fin;
    end else begin
      o_req = d_req; o_addr = d_addr; o_win = d_win; o_wv = d_wv;
      o_lv = d_lv; o_laddr = d_laddr; o_ldata = d_ldata; o_fin = d_fin;
    end
  end

  int          checks, errors;
  int          W, pend, fixed_res, stall_g, stall_w, wv_cycles, n_writes, last_waddr;
  bit          rand_gray, rand_win, spur;
  logic [7:0]  pend_dat;
  int          exp_rd[$];
  logic [71:0] exp_win[$];
  int          exp_pix[$];
  logic [7:0]  exp_res[$];
  int          rd_log[$];
  int          e9[9] = '{128, 256, 384, 129, 257, 385, 130, 258, 386};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] memval(input int a);
    logic [31:0] t;
    t = a;
    return sel ? mem_s[t[7:0]] : t[7:0];
  endfunction

  // Reference: every interior pixel in raster order, its reads, its window (p = 3*dy + dx) and its address
  task automatic build(input int w);
    exp_rd.delete(); exp_win.delete(); exp_pix.delete(); exp_res.delete();
    for (int r = 1; r <= w - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        logic [71:0] wv;
        if (c == 1) begin
          for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++) exp_rd.push_back((r - 1 + i) * w + j);
        end else begin
          for (int i = 0; i < 3; i++) exp_rd.push_back((r - 1 + i) * w + c + 1);
        end
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) wv[(i*3+j)*8 +: 8] = memval((r - 1 + i) * w + c - 1 + j);
        exp_win.push_back(wv);
        exp_pix.push_back(r * w + c);
      end
    end
  endtask

  task automatic cyc();
    logic        busy;
    logic [71:0] wtmp;
    int          itmp;
    @(negedge clk);
    busy = o_wv || o_lv;
    if (stall_g > 0) begin gray_ready = 1'b0; stall_g--; end
    else gray_ready = rand_gray ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stall_w > 0 && o_wv) begin win_ready = 1'b0; stall_w--; end
    else win_ready = rand_win ? ($urandom_range(0, 2) != 0) : 1'b1;
    res_valid = 1'b0;
    res_data  = 8'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        res_valid = 1'b1; res_data = pend_dat; exp_res.push_back(pend_dat);
      end
    end else if (spur && busy && $urandom_range(0, 2) == 0) begin
      res_valid = 1'b1;
    end
    #1;
    chk("excl", ($countones({o_req, o_wv, o_lv, o_fin}) <= 1), 1'b1);
    if (o_req) begin
      chk("req_rdy", gray_ready, 1'b1);
      rd_log.push_back(int'(o_addr));
      if (exp_rd.size() > 0) begin
        itmp = exp_rd.pop_front();
        chk("rd_addr", o_addr, itmp);
      end else chk("rd_extra", o_addr, -1);
    end
    if (o_wv) begin
      wv_cycles++;
      if (exp_win.size() > 0) begin
        chk("win", o_win, exp_win[0]);
        if (win_ready) begin
          wtmp = exp_win.pop_front();
          pend = 2;
          pend_dat = (fixed_res >= 0) ? 8'(fixed_res) : 8'($urandom);
        end
      end else chk("win_extra", o_wv, 1'b0);
    end
    if (o_lv) begin
      n_writes++;
      last_waddr = int'(o_laddr);
      if (exp_pix.size() > 0) begin
        itmp = exp_pix.pop_front();
        chk("wr_addr", o_laddr, itmp);
      end else chk("wr_extra", o_laddr, -1);
      if (exp_res.size() > 0) begin
        wtmp = 72'(exp_res.pop_front());
        chk("wr_data", o_ldata, wtmp);
      end else chk("wr_nores", o_lv, 1'b0);
    end
  endtask

  function automatic bit ev(input int kind, input int addr);
    case (kind)
      0:       return o_wv;
      1:       return o_lv && (addr < 0 || int'(o_laddr) == addr);
      2:       return o_fin;
      default: return o_req;
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int addr, input int budget, input string tag);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!ev(kind, addr) && n < budget);
    chk(tag, ev(kind, addr), 1'b1);
  endtask

  task automatic hit_reset(input bit s);
    @(negedge clk);
    #2;
    if (s) rst_s = 1'b0; else rst_d = 1'b0;
    #1;
    chk("rst_req", o_req, 1'b0);     chk("rst_addr", o_addr, 0);
    chk("rst_win", o_win, 0);        chk("rst_wv", o_wv, 1'b0);
    chk("rst_lv", o_lv, 1'b0);       chk("rst_laddr", o_laddr, 0);
    chk("rst_ldata", o_ldata, 0);    chk("rst_fin", o_fin, 1'b0);
    pend = 0; res_valid = 1'b0; stall_g = 0; stall_w = 0; n_writes = 0;
    build(W);
    rd_log.delete();
    repeat (2) @(negedge clk);
    if (s) rst_s = 1'b1; else rst_d = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; sel = 1'b0; rst_d = 1'b0; rst_s = 1'b0;
    gray_ready = 1'b0; win_ready = 1'b0; res_valid = 1'b0; res_data = 8'd0;
    rand_gray = 1'b0; rand_win = 1'b0; spur = 1'b0; fixed_res = 8'hA5;
    stall_g = 0; stall_w = 0; pend = 0; wv_cycles = 0; n_writes = 0; last_waddr = -1;
    for (int i = 0; i < 256; i++) mem_s[i] = 8'($urandom);

    // Default-size instance: first window and first write
    W = 128;
    hit_reset(1'b0);
    wait_ev(0, -1, 100, "first_win");
    chk("rd9_count", rd_log.size(), 9);
    for (int i = 0; i < 9; i++) chk("rd9_addr", rd_log[i], ((i % 3) * 128) + (i / 3));
    chk("p4", o_win[39:32], 8'h81);
    chk("p0", o_win[7:0], 8'h00);
    chk("p8", o_win[71:64], 8'h02);
    wait_ev(1, -1, 100, "first_wr");
    chk("wr1_addr", o_laddr, 129);
    chk("wr1_data", o_ldata, 8'hA5);
    rd_log.delete();
    cyc();
    chk("lv_once", o_lv, 1'b0);
    wait_ev(0, -1, 100, "win2");
    chk("rd3_count", rd_log.size(), 3);
    chk("rd3_a", rd_log[0], 3); chk("rd3_b", rd_log[1], 131); chk("rd3_c", rd_log[2], 259);

    // gray_ready stall in the middle of a column fetch
    wait_ev(3, -1, 100, "fetch3");
    stall_g = 5;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_req", o_req, 1'b0);
      chk("stall_addr", o_addr, exp_rd[0]);
    end
    wait_ev(1, -1, 100, "wr3");

    // win_ready held low 10 cycles with spurious results flying around
    fixed_res = -1; spur = 1'b1; stall_w = 10; wv_cycles = 0;
    wait_ev(1, -1, 200, "wr4");
    chk("issue_len", wv_cycles, 11);
    chk("wr4_addr", o_laddr, 132);

    // Randomized stalls to the end of row 1, then the row wrap
    rand_gray = 1'b1; rand_win = 1'b1;
    wait_ev(1, 254, 20000, "wr_row_end");
    rd_log.delete();
    wait_ev(0, -1, 200, "wrap_win");
    chk("wrap_count", rd_log.size(), 9);
    for (int i = 0; i < 9; i++) chk("wrap_addr", rd_log[i], e9[i]);

    // Mid-frame reset and restart
    repeat (40) cyc();
    hit_reset(1'b0);
    wait_ev(3, -1, 100, "restart_d");
    chk("restart_d_addr", o_addr, 0);
    wait_ev(1, -1, 300, "restart_d_wr");

    // 16x16 instance: mid-frame reset, then a complete frame
    rst_d = 1'b0; sel = 1'b1; W = 16;
    hit_reset(1'b1);
    wait_ev(1, 5 * 16 + 7, 20000, "s_row5");
    hit_reset(1'b1);
    wait_ev(3, -1, 100, "restart_s");
    chk("restart_s_addr", o_addr, 0);
    wait_ev(2, -1, 40000, "s_finish");
    chk("n_writes", n_writes, 196);
    chk("last_waddr", last_waddr, 238);
    chk("rd_left", exp_rd.size(), 0);
    chk("win_left", exp_win.size(), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fin_hold", o_fin, 1'b1);
      chk("fin_quiet", {o_req, o_wv, o_lv}, 3'b000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
